// File: rtl/instr_sequencer.sv
// simplex8 fetch/decode/execute sequencer: PC, fetch handshake,
// decoder enable, datapath strobes, data-memory waits, halt/fault.
//
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   pmem_addr/req/ack/data program fetch handshake (addr = PC)
//   instr, dec_en          latched instruction and decoder enable
//   dec_op, dec_*          decoder one-hot op and class lines
//   br_take, br_target     branch redirect, sampled in EXEC
//   load_acc, set_flags,
//   reg_we                 single-cycle datapath strobes
//   dmem_req, dmem_ack     data memory handshake
//   halted, fault          stopped core / sticky memory timeout
//   step                   only with SINGLE_STEP_EN: run one instr
//
// Optional feature macro: SINGLE_STEP_EN
module instr_sequencer #(
  parameter int              PC_W        = 8,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset_n,
`ifdef SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic [PC_W-1:0] pmem_addr,
  output logic            pmem_req,
  input  logic            pmem_ack,
  input  logic [7:0]      pmem_data,
  output logic [7:0]      instr,
  output logic            dec_en,
  input  logic [15:0]     dec_op,
  input  logic            dec_loadacc,
  input  logic            dec_setflags,
  input  logic            dec_reg,
  input  logic            dec_mem,
  input  logic            br_take,
  input  logic [PC_W-1:0] br_target,
  output logic            load_acc,
  output logic            set_flags,
  output logic            reg_we,
  output logic            dmem_req,
  input  logic            dmem_ack,
  output logic            halted,
  output logic            fault
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEMW,
    S_HALT
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t          state, state_d;
  logic [PC_W-1:0] pc, pc_d;
  logic [7:0]      instr_q, instr_d;
  logic [7:0]      cnt, cnt_d;
  logic            hlt_q, hlt_d;
  logic            mem_q, mem_d;
  logic [2:0]      cls_q, cls_d;
  logic            fault_q, fault_d;
  logic            run;

  logic            req_c, den_c, dreq_c, halt_c;
  logic [2:0]      strb_c;

  // Only opcode 0 (HLT) of the one-hot op bus matters here.
  logic            unused_op;
  assign unused_op = ^dec_op[15:1];

`ifdef SINGLE_STEP_EN
  // go_q holds the grant for the instruction in flight so a
  // one-cycle step pulse carries it through to completion.
  logic go_q, go_d;
  assign run = go_q | step;
`else
  assign run = 1'b1;
`endif

  always_comb begin
    state_d = state;
    pc_d    = pc;
    instr_d = instr_q;
    cnt_d   = cnt;
    hlt_d   = hlt_q;
    mem_d   = mem_q;
    cls_d   = cls_q;
    fault_d = fault_q;
    req_c   = 1'b0;
    den_c   = 1'b0;
    dreq_c  = 1'b0;
    halt_c  = 1'b0;
    strb_c  = 3'b000;
`ifdef SINGLE_STEP_EN
    go_d    = go_q;
`endif
    unique case (state)
      S_FETCH: begin
        if (run) begin
          req_c = 1'b1;
`ifdef SINGLE_STEP_EN
          go_d  = 1'b1;
`endif
          if (pmem_ack) begin
            instr_d = pmem_data;
            pc_d    = pc + PC_W'(1);
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        den_c   = 1'b1;
        hlt_d   = dec_op[0];
        mem_d   = dec_mem;
        cls_d   = {dec_loadacc, dec_setflags, dec_reg};
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (hlt_q) begin
          state_d = S_HALT;
        end else if (mem_q) begin
          cnt_d   = '0;
          state_d = S_MEMW;
        end else begin
          strb_c  = cls_q;
          if (br_take) pc_d = br_target;
          state_d = S_FETCH;
`ifdef SINGLE_STEP_EN
          go_d    = 1'b0;
`endif
        end
      end
      S_MEMW: begin
        dreq_c = 1'b1;
        // cnt counts completed wait cycles, so an ack in the
        // last allowed cycle still wins over the timeout.
        if (dmem_ack) begin
          strb_c  = cls_q;
          cnt_d   = '0;
          state_d = S_FETCH;
`ifdef SINGLE_STEP_EN
          go_d    = 1'b0;
`endif
        end else if (cnt == CNT_LAST) begin
          fault_d = 1'b1;
          cnt_d   = '0;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      S_HALT: begin
        halt_c = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      instr_q <= '0;
      cnt     <= '0;
      hlt_q   <= 1'b0;
      mem_q   <= 1'b0;
      cls_q   <= '0;
      fault_q <= 1'b0;
`ifdef SINGLE_STEP_EN
      go_q    <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      pc      <= pc_d;
      instr_q <= instr_d;
      cnt     <= cnt_d;
      hlt_q   <= hlt_d;
      mem_q   <= mem_d;
      cls_q   <= cls_d;
      fault_q <= fault_d;
`ifdef SINGLE_STEP_EN
      go_q    <= go_d;
`endif
    end
  end

  // Held reset silences every request and strobe, whatever the
  // state register still says before the reset edge.
  assign pmem_addr = pc;
  assign instr     = instr_q;
  assign fault     = fault_q;
  assign pmem_req  = req_c & reset_n;
  assign dec_en    = den_c & reset_n;
  assign dmem_req  = dreq_c & reset_n;
  assign halted    = halt_c & reset_n;
  assign load_acc  = strb_c[2] & reset_n;
  assign set_flags = strb_c[1] & reset_n;
  assign reg_we    = strb_c[0] & reset_n;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: per-instruction
// reference of fetch/decode/exec/memory timing, PC and strobes.
module tb_instr_sequencer;

  localparam int         TMO = 15;
  localparam logic [7:0] RPC = 8'h00;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        step = 1'b1;
  logic [7:0]  pmem_addr;
  logic        pmem_req, pmem_ack;
  logic [7:0]  pmem_data, instr;
  logic        dec_en;
  logic [15:0] dec_op;
  logic        dec_loadacc, dec_setflags, dec_reg, dec_mem;
  logic        br_take;
  logic [7:0]  br_target;
  logic        load_acc, set_flags, reg_we;
  logic        dmem_req, dmem_ack, halted, fault;

  logic [7:0]  pmem [256];
  int          ntests = 0;
  int          nfail = 0;
  logic [7:0]  mpc;
  logic        mfault;

  always #5 clk = ~clk;

  instr_sequencer #(
    .PC_W(8), .RESET_PC(RPC), .MEM_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .pmem_addr(pmem_addr), .pmem_req(pmem_req),
    .pmem_ack(pmem_ack), .pmem_data(pmem_data),
    .instr(instr), .dec_en(dec_en), .dec_op(dec_op),
    .dec_loadacc(dec_loadacc), .dec_setflags(dec_setflags),
    .dec_reg(dec_reg), .dec_mem(dec_mem),
    .br_take(br_take), .br_target(br_target),
    .load_acc(load_acc), .set_flags(set_flags),
    .reg_we(reg_we), .dmem_req(dmem_req),
    .dmem_ack(dmem_ack), .halted(halted), .fault(fault)
  );

  // Toy ISA: opcode = high nibble. 0 HLT, 10..12 memory,
  // 13..15 NOP. Returns {load_acc, set_flags, reg_we}.
  function automatic logic [2:0] cls3(input logic [7:0] b);
    case (b[7:4])
      4'd1:    return 3'b100;
      4'd2:    return 3'b010;
      4'd3:    return 3'b001;
      4'd4:    return 3'b110;
      4'd5:    return 3'b110;
      4'd6:    return 3'b011;
      4'd7:    return 3'b111;
      4'd8:    return 3'b101;
      4'd9:    return 3'b001;
      4'd10:   return 3'b100;
      4'd11:   return 3'b001;
      4'd12:   return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic is_mem(input logic [7:0] b);
    return (b[7:4] >= 4'd10) && (b[7:4] <= 4'd12);
  endfunction

  assign pmem_data = pmem[pmem_addr];
  assign dec_op    = 16'b1 << instr[7:4];
  assign {dec_loadacc, dec_setflags, dec_reg} = cls3(instr);
  assign dec_mem   = is_mem(instr);

  wire [2:0] strb = {load_acc, set_flags, reg_we};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; pmem_ack = 1'b0; dmem_ack = 1'b0;
    br_take = 1'b0; br_target = '0;
    @(negedge clk); #1;
    chk("rst_req", 32'(pmem_req), 0);
    chk("rst_addr", 32'(pmem_addr), 32'(RPC));
    chk("rst_instr", 32'(instr), 0);
    chk("rst_dec_en", 32'(dec_en), 0);
    chk("rst_strb", 32'(strb), 0);
    chk("rst_dreq", 32'(dmem_req), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_fault", 32'(fault), 0);
    mpc = RPC; mfault = 1'b0;
  endtask

  // Fetch (pwait stall cycles), decode and exec of one instruction.
  task automatic front(input logic [7:0] op, input int pwait,
                       input logic br, input logic [7:0] tgt);
    for (int k = 0; k <= pwait; k++) begin
      @(negedge clk);
      reset_n = 1'b1;
      pmem_ack = (k == pwait);
      dmem_ack = 1'($urandom);
      br_take = 1'b1;
      br_target = 8'($urandom);
      #1;
      chk("fetch_req", 32'(pmem_req), 1);
      chk("fetch_addr", 32'(pmem_addr), 32'(mpc));
      chk("fetch_strb", 32'(strb), 0);
      chk("fetch_dec_en", 32'(dec_en), 0);
    end
    @(negedge clk);
    pmem_ack = 1'($urandom);
    dmem_ack = 1'($urandom);
    br_take = 1'($urandom);
    #1;
    chk("dec_en", 32'(dec_en), 1);
    chk("dec_instr", 32'(instr), 32'(op));
    chk("dec_req", 32'(pmem_req), 0);
    chk("dec_strb", 32'(strb), 0);
    @(negedge clk);
    br_take = br; br_target = tgt;
    pmem_ack = 1'($urandom);
    dmem_ack = 1'($urandom);
    #1;
    chk("exec_dec_en", 32'(dec_en), 0);
    chk("exec_dreq", 32'(dmem_req), 0);
    chk("exec_strb", 32'(strb),
        (op[7:4] == 4'd0 || is_mem(op)) ? 0 : 32'(cls3(op)));
  endtask

  // Memory wait phase; ack arrives in cycle dwait (0-based).
  task automatic memw(input logic [7:0] op, input int dwait,
                      output logic flt);
    flt = 1'b1;
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk);
      dmem_ack = (k == dwait);
      pmem_ack = 1'($urandom);
      br_take = 1'($urandom);
      #1;
      chk("memw_dreq", 32'(dmem_req), 1);
      chk("memw_strb", 32'(strb),
          (k == dwait) ? 32'(cls3(op)) : 0);
      if (k == dwait) begin
        flt = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_instr(input logic [7:0] op, input int pwait,
                          input int dwait, input logic br,
                          input logic [7:0] tgt);
    logic flt;
    pmem[mpc] = op;
    front(op, pwait, br, tgt);
    if (is_mem(op)) begin
      memw(op, dwait, flt);
      if (flt) mfault = 1'b1;
      mpc = mpc + 8'd1;
    end else if (op[7:4] == 4'd0) begin
      mpc = mpc + 8'd1;
    end else begin
      mpc = br ? tgt : mpc + 8'd1;
    end
  endtask

  task automatic check_halt(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      reset_n = 1'b1;
      pmem_ack = 1'($urandom);
      dmem_ack = 1'($urandom);
      br_take = 1'($urandom);
      br_target = 8'($urandom);
      #1;
      chk("halt_halted", 32'(halted), 1);
      chk("halt_req", 32'(pmem_req), 0);
      chk("halt_dreq", 32'(dmem_req), 0);
      chk("halt_strb", 32'(strb), 0);
      chk("halt_addr", 32'(pmem_addr), 32'(mpc));
      chk("halt_fault", 32'(fault), 32'(mfault));
    end
  endtask

  initial begin
    logic flt;
    logic [7:0] op;
    reset_n = 1'b0; pmem_ack = 1'b0; dmem_ack = 1'b0;
    br_take = 1'b0; br_target = '0;
    for (int i = 0; i < 256; i++) pmem[i] = 8'hD0;
    mpc = RPC; mfault = 1'b0;

    do_reset();
    do_instr(8'h51, 0, 0, 1'b0, 8'h00);
    do_instr(8'h52, 0, 0, 1'b0, 8'h00);
    do_instr(8'h53, 0, 0, 1'b0, 8'h00);
    do_instr(8'hD0, 0, 0, 1'b0, 8'h00);
    do_instr(8'hE0, 0, 0, 1'b0, 8'h00);
    do_instr(8'h10, 0, 0, 1'b1, 8'h40);
    do_instr(8'hA0, 1, 3, 1'b1, 8'h77);
    do_instr(8'hB5, 0, TMO - 1, 1'b0, 8'h00);
    do_instr(8'hF0, 2, 0, 1'b0, 8'h00);

    for (int n = 0; n < 40; n++) begin
      op = {4'($urandom_range(1, 15)), 4'($urandom)};
      do_instr(op, $urandom_range(0, 2), $urandom_range(0, 6),
               1'($urandom), 8'($urandom));
    end

    do_instr(8'h90, 0, 0, 1'b1, 8'hFF);
    do_instr(8'h70, 2, 0, 1'b0, 8'h00);
    do_instr(8'h00, 0, 0, 1'b0, 8'h00);
    check_halt(6);

    do_reset();
    do_instr(8'h31, 0, 0, 1'b0, 8'h00);
    do_instr(8'hC0, 0, 99, 1'b0, 8'h00);
    check_halt(4);

    do_reset();
    pmem[mpc] = 8'hA3;
    front(8'hA3, 0, 1'b0, 8'h00);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      dmem_ack = 1'b0;
      #1;
      chk("pre_rst_dreq", 32'(dmem_req), 1);
    end
    @(negedge clk);
    reset_n = 1'b0; dmem_ack = 1'b1;
    @(posedge clk); #1;
    chk("mrst_dreq", 32'(dmem_req), 0);
    chk("mrst_strb", 32'(strb), 0);
    chk("mrst_req", 32'(pmem_req), 0);
    chk("mrst_addr", 32'(pmem_addr), 32'(RPC));
    chk("mrst_fault", 32'(fault), 0);
    mpc = RPC; mfault = 1'b0;
    do_instr(8'hA1, 0, 0, 1'b0, 8'h00);
    do_instr(8'h81, 1, 0, 1'b0, 8'h00);
    do_instr(8'h00, 0, 0, 1'b0, 8'h00);
    check_halt(3);

    flt = 1'b0;
    if (flt) nfail++;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
